// File: rtl/song_pkg.sv
// Shared song-path definitions: field widths, player count, arbiter state enum.
// Reused by the song reader, the note-player arbiter and the note players.
package song_pkg;

    localparam int SONG_NUM_PLAYERS = 3;
    localparam int SONG_NOTE_W      = 6;
    localparam int SONG_DUR_W       = 6;
    localparam int SONG_AGE_W       = 8;
    localparam int MAX_PLAYERS      = 8;
    localparam int PTR_W            = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_PLAYERS-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            if (v[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Rotating first-free search: one-hot grant for the first free player at or after i_start, wrapping.
// Purely combinational, zero latency, no backpressure.
module rr_free_picker
    import song_pkg::*;
#(
    parameter int N = SONG_NUM_PLAYERS
) (
    input  logic [N-1:0]     i_free,
    input  logic [PTR_W-1:0] i_start,
    output logic [N-1:0]     o_grant,
    output logic             o_found
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap: N need not be a power of two
            w_idx = int'(i_start) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!o_found && i_free[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_player_arbiter.sv
// Round-robin allocator of note requests to players; load one cycle after accept, req_ready low while a note is pending.
// Optional NOTE_STEAL_EN pre-empts the oldest busy player after one full stall cycle.
module note_player_arbiter
    import song_pkg::*;
#(
    parameter int NUM_PLAYERS = SONG_NUM_PLAYERS,
    parameter int NOTE_W      = SONG_NOTE_W,
    parameter int DUR_W       = SONG_DUR_W,
    parameter int AGE_W       = SONG_AGE_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NOTE_W-1:0]      req_note,
    input  logic [DUR_W-1:0]       req_duration,
    input  logic                   flush,
    input  logic [NUM_PLAYERS-1:0] note_done,
    output logic [NUM_PLAYERS-1:0] load,
    output logic [NOTE_W-1:0]      load_note,
    output logic [DUR_W-1:0]       load_duration,
    output logic [NUM_PLAYERS-1:0] busy,
    output logic                   all_busy,
    output logic                   stolen
);

    state_e                 r_state, w_state_nxt;
    logic [NUM_PLAYERS-1:0] r_busy;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [NOTE_W-1:0]      r_hold_note;
    logic [DUR_W-1:0]       r_hold_dur;

    logic [NUM_PLAYERS-1:0] w_free, w_grant, w_load, w_victim;
    logic                   w_found, w_full, w_live, w_steal;
    logic [PTR_W-1:0]       w_grant_idx, w_rr_nxt;

    assign w_free = ~r_busy;
    assign w_full = &r_busy;
    // A load is never issued in a cycle that is being reset or flushed.
    assign w_live = reset_n && !flush;

    rr_free_picker #(
        .N (NUM_PLAYERS)
    ) u_picker (
        .i_free  (w_free),
        .i_start (r_rr_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    assign w_grant_idx = onehot_to_idx(MAX_PLAYERS'(w_grant));
    assign w_rr_nxt    = (w_grant_idx == PTR_W'(NUM_PLAYERS - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef NOTE_STEAL_EN
    logic [AGE_W-1:0] r_age [NUM_PLAYERS];
    logic             r_waited;
    int               w_old_idx;

    // Oldest busy player; strict compare keeps ties on the lowest index.
    always_comb begin
        w_old_idx = 0;
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (r_age[i] > r_age[w_old_idx]) w_old_idx = i;
        end
        w_victim            = '0;
        w_victim[w_old_idx] = 1'b1;
    end

    assign w_steal = (r_state == STALL) && w_full && r_waited;
    assign stolen  = w_steal && w_live;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_waited <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_age[i] <= '0;
        end else begin
            r_waited <= (r_state == STALL) && w_full && !w_steal;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (w_load[i])
                    r_age[i] <= '0;
                else if (r_busy[i] && (r_age[i] != {AGE_W{1'b1}}))
                    r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end
`else
    assign w_victim = '0;
    assign w_steal  = 1'b0;
    assign stolen   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) w_state_nxt = w_full ? STALL : ISSUE;
            end
            ISSUE: begin
                w_load      = w_found ? w_grant : '0;
                w_state_nxt = IDLE;
            end
            STALL: begin
                if (!w_full) begin
                    w_state_nxt = ISSUE;
                end else if (w_steal) begin
                    w_load      = w_victim;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!w_live) begin
            w_load      = '0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= '0;
            r_rr_ptr    <= '0;
            r_hold_note <= '0;
            r_hold_dur  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= flush ? '0 : ((r_busy & ~note_done) | w_load);
            if (flush) begin
                r_hold_note <= '0;
                r_hold_dur  <= '0;
            end else if ((r_state == IDLE) && req_valid) begin
                r_hold_note <= req_note;
                r_hold_dur  <= req_duration;
            end
            // steals leave the round-robin pointer alone
            if ((r_state == ISSUE) && w_found && w_live) r_rr_ptr <= w_rr_nxt;
        end
    end

    assign req_ready     = (r_state == IDLE) && !flush;
    assign load          = w_load;
    assign load_note     = (|w_load) ? r_hold_note : '0;
    assign load_duration = (|w_load) ? r_hold_dur  : '0;
    assign busy          = r_busy;
    assign all_busy      = w_full;

endmodule

// File: tb/tb_note_player_arbiter.sv
// Self-checking bench: directed test-plan sequence with literal expectations, then random traffic
// compared every cycle against a request/occupancy model of the arbiter.
module tb_note_player_arbiter;

    localparam int N    = 3;
    localparam int NW   = 6;
    localparam int DW   = 6;
    localparam int AW   = 8;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset_n, req_valid, flush;
    logic [NW-1:0] req_note;
    logic [DW-1:0] req_duration;
    logic [N-1:0]  note_done;
    logic          req_ready, all_busy, stolen;
    logic [N-1:0]  load, busy;
    logic [NW-1:0] load_note;
    logic [DW-1:0] load_duration;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    note_player_arbiter #(
        .NUM_PLAYERS (N),
        .NOTE_W      (NW),
        .DUR_W       (DW),
        .AGE_W       (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_note      (req_note),
        .req_duration  (req_duration),
        .flush         (flush),
        .note_done     (note_done),
        .load          (load),
        .load_note     (load_note),
        .load_duration (load_duration),
        .busy          (busy),
        .all_busy      (all_busy),
        .stolen        (stolen)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a pending request, the cycle it may issue (-1 while waiting for a free player),
    // per-player occupancy and age, and the round-robin start position.
    bit       m_known = 1'b0;
    bit [N-1:0] m_busy;
    int       m_rr, m_note, m_dur, m_issue_at, m_stall_from;
    bit       m_pend;
    int       m_age [N];

    always @(negedge clk) begin : cmp
        int       e_load, e_idx;
        bit       e_steal, full, accept;
        bit [N-1:0] nb;
        e_load  = 0;
        e_idx   = 0;
        e_steal = 1'b0;
        full    = (m_busy == {N{1'b1}});
        accept  = req_valid && !m_pend && !flush;
        if (m_known && m_pend && reset_n && !flush) begin
            if (m_issue_at == cyc) begin
                for (int k = 0; k < N; k++) begin
                    if (e_load == 0 && !m_busy[(m_rr + k) % N]) begin
                        e_idx  = (m_rr + k) % N;
                        e_load = 1 << e_idx;
                    end
                end
            end
`ifdef NOTE_STEAL_EN
            else if (m_issue_at < 0 && full && cyc > m_stall_from) begin
                for (int i = 1; i < N; i++) if (m_age[i] > m_age[e_idx]) e_idx = i;
                e_load  = 1 << e_idx;
                e_steal = 1'b1;
            end
`endif
        end
        if (m_known) begin
            if (reset_n) begin
                check("req_ready", int'(req_ready), int'(!m_pend && !flush));
                check("load", int'(load), e_load);
                check("load_note", int'(load_note), (e_load != 0) ? m_note : 0);
                check("load_duration", int'(load_duration), (e_load != 0) ? m_dur : 0);
                check("busy", int'(busy), int'(m_busy));
                check("all_busy", int'(all_busy), int'(full));
                check("stolen", int'(stolen), int'(e_steal));
            end else begin
                check("load_in_reset", int'(load), 0);
            end
        end
        if (!reset_n) begin
            m_known    = 1'b1;
            m_busy     = '0;
            m_rr       = 0;
            m_pend     = 1'b0;
            m_issue_at = -1;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else if (m_known) begin
            for (int i = 0; i < N; i++) begin
                if (e_load[i])                        m_age[i] = 0;
                else if (m_busy[i] && m_age[i] < AMAX) m_age[i] = m_age[i] + 1;
            end
            if (flush) begin
                m_busy = '0;
                m_pend = 1'b0;
            end else begin
                nb = (m_busy & ~note_done) | N'(e_load);
                if (e_load != 0) begin
                    m_pend = 1'b0;
                    if (!e_steal) m_rr = (e_idx + 1) % N;
                end else if (m_pend && m_issue_at < 0 && !full) begin
                    m_issue_at = cyc + 1;
                end
                if (accept) begin
                    m_pend = 1'b1;
                    m_note = int'(req_note);
                    m_dur  = int'(req_duration);
                    if (!full) m_issue_at = cyc + 1;
                    else begin
                        m_issue_at   = -1;
                        m_stall_from = cyc + 1;
                    end
                end
                m_busy = nb;
            end
        end
        cyc++;
    end

    task automatic step(input bit v, input int n, input int d, input bit f, input int done, input bit rst);
        @(posedge clk);
        #1;
        req_valid    = v;
        req_note     = NW'(n);
        req_duration = DW'(d);
        flush        = f;
        note_done    = N'(done);
        reset_n      = rst;
        #2;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0;
        req_note = '0; req_duration = '0; note_done = '0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // three back-to-back notes fill the players in order
        step(1, 10, 4, 0, 0, 1); check("lit_ready_after_reset", int'(req_ready), 1);
                                 check("lit_busy_after_reset", int'(busy), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_load0", int'(load), 1); check("lit_note0", int'(load_note), 10);
        step(1, 11, 4, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_load1", int'(load), 2);
        step(1, 12, 4, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_load2", int'(load), 4);
        // fourth note stalls until player 1 finishes
        step(1, 13, 5, 0, 0, 1); check("lit_busy_full", int'(busy), 7); check("lit_all_busy", int'(all_busy), 1);
        step(0, 0, 0, 0, 2, 1);  check("lit_stall_ready", int'(req_ready), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_stall_noload", int'(load), 0); check("lit_busy_freed", int'(busy), 5);
        step(0, 0, 0, 0, 0, 1);  check("lit_stall_load", int'(load), 2); check("lit_stall_note", int'(load_note), 13);
                                 check("lit_stall_dur", int'(load_duration), 5);
        // wrap: pointer at 2, player 2 busy -> player 0, pointer moves to 1
        step(0, 0, 0, 0, 3, 1);
        step(1, 20, 1, 0, 0, 1); check("lit_wrap_busy", int'(busy), 4);
        step(0, 0, 0, 0, 0, 1);  check("lit_wrap_load", int'(load), 1);
        step(0, 0, 0, 0, 5, 1);
        step(1, 21, 2, 0, 0, 1); check("lit_all_free", int'(busy), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_rr_after_wrap", int'(load), 2);
        // fill again, then flush while stalled
        step(1, 22, 3, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_fill_a", int'(load), 4);
        step(1, 23, 3, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_fill_b", int'(load), 1);
        step(1, 24, 4, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);  check("lit_flush_noload", int'(load), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_flush_busy", int'(busy), 0); check("lit_flush_ready", int'(req_ready), 1);
                                 check("lit_flush_discard", int'(load), 0);
        // reset during ISSUE
        step(1, 25, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);  check("lit_reset_noload", int'(load), 0);
        step(1, 26, 1, 0, 0, 1); check("lit_reset_ready", int'(req_ready), 1); check("lit_reset_busy", int'(busy), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_reset_rr", int'(load), 1);

`ifdef NOTE_STEAL_EN
        step(0, 0, 0, 0, 0, 0);
        step(1, 30, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 31, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 32, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 33, 2, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_steal_wait", int'(load), 0);
        step(0, 0, 0, 0, 0, 1);  check("lit_steal_p0", int'(load), 1); check("lit_stolen0", int'(stolen), 1);
                                 check("lit_steal_note", int'(load_note), 33);
        step(1, 34, 2, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);  check("lit_steal_p1", int'(load), 2); check("lit_stolen1", int'(stolen), 1);
`endif

        for (int c = 0; c < 4000; c++) begin
            int done;
            done = 0;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) done |= (1 << i);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 39) == 0, done, $urandom_range(0, 199) != 0);
        end
        step(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
